instr_fetch_reg: RTL and testbench
==================================

INSTR_FETCH_REG -- requirements
Module: instr_fetch_reg

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word-aligned fetch address.
REQ-006 imem_ready  input  1  read data valid this cycle; meaningful only while imem_req=1.
REQ-007 imem_rdata  input  32  instruction word.
REQ-008 ir_valid  output  1  IR holds an unconsumed instruction.
REQ-009 ir_ready  input  1  downstream decode accepts IR this cycle.
REQ-010 ir  output  32  instruction register.
REQ-011 imm16  output  16  ir[15:0], the feed to the downstream 16-to-32 sign-extension stage.
REQ-012 pc  output  32  address of the instruction held in ir.
REQ-013 pc_plus4  output  32  pc+4, modulo 2^32.
REQ-014 redirect  input  1  branch/jump: discard current fetch and restart at redirect_pc.
REQ-015 redirect_pc  input  32  new fetch address; bits [1:0] SHALL be ignored and treated as 00.
REQ-016 fetch_count  output  32  number of instructions handed downstream.

Function
REQ-017 FSM states SHALL be REQ, HOLD and DRAIN.
REQ-018 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal fetch_pc; on imem_ready=1, ir<=imem_rdata, pc<=fetch_pc, ir_valid<=1, next state HOLD.
REQ-019 While imem_req=1 and imem_ready=0, imem_addr SHALL be held stable; a request SHALL never be withdrawn before imem_ready.
REQ-020 In HOLD, imem_req SHALL be 0 and ir_valid=1; on ir_ready=1: ir_valid<=0, fetch_pc<=fetch_pc+4, fetch_count<=fetch_count+1, next state REQ.
REQ-021 ir, pc and imm16 SHALL remain stable while ir_valid=1 and ir_ready=0.
REQ-022 Latency: the first IR-valid cycle SHALL follow the imem_ready cycle by exactly one clock; a back-to-back fetch with imem_ready held at 1 SHALL sustain one instruction per 2 cycles.
REQ-023 Redirect in HOLD or in REQ with imem_ready=1 in the same cycle: fetch_pc<=redirect_pc, ir_valid<=0, the response SHALL be discarded, fetch_count unchanged, next state REQ.
REQ-024 Redirect in REQ with imem_ready=0: fetch_pc<=redirect_pc, next state DRAIN, where imem_req stays 1 on the old address until imem_ready, the data is discarded, and the next state is REQ.
REQ-025 Redirect in DRAIN SHALL overwrite fetch_pc and remain in DRAIN.
REQ-026 Redirect has priority over ir_ready; a simultaneous ir_ready SHALL NOT count or advance pc.
REQ-027 fetch_pc and pc_plus4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000; fetch_count SHALL wrap from 2^32-1 to 0.

Reset
REQ-028 rst=1 SHALL immediately force state=REQ, fetch_pc=RESET_PC, ir=0, pc=RESET_PC, ir_valid=0, fetch_count=0; imem_req SHALL be 0 while rst=1.
REQ-029 Reset asserted mid-fetch SHALL abandon the outstanding request; the memory SHALL be reset alongside.

Structure
REQ-030 The FSM state encoding and the 32-bit instruction/address width constants SHALL live in the shared CPU package.
REQ-031 One sub-module, pc_reg (32-bit loadable register with +4 increment and async reset to RESET_PC), is natural; the rest is inline.

Verification
REQ-032 Reset release with RESET_PC=0, imem_ready=1 at cycle 1, rdata=32'h2008_FFFF -> ir_valid at cycle 2, imm16=16'hFFFF, pc=0, pc_plus4=4.
REQ-033 imem_ready low for 3 cycles -> imem_addr constant and imem_req held at 1 for 4 cycles, then IR loads.
REQ-034 ir_ready low for 5 cycles in HOLD -> ir, pc stable and no new imem_req; on accept, fetch_count increments by 1 and next addr=pc+4.
REQ-035 Redirect to 32'h0000_0103 while waiting -> DRAIN finishes old address, data discarded, next request addr=32'h0000_0100.
REQ-036 Redirect coincident with ir_ready and with imem_ready -> fetch_count unchanged, ir_valid=0, next addr=redirect target.
REQ-037 Start at fetch_pc=32'hFFFF_FFFC, accept -> next imem_addr=0; rst pulsed mid-wait -> outputs at reset values the same cycle.

Source files
------------

// File: rtl/instr_fetch_reg_pkg.sv
// Shared CPU constants and the fetch FSM state encoding.
// The package is imported by both the fetch top and its fetch-address register.
package instr_fetch_reg_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;
   localparam logic [XLEN-1:0] ADDR_STEP = 32'd4;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_reg_pc_reg.sv
// Loadable 32-bit address register with a +4 increment.
// Its asynchronous reset returns the register to RESET_VAL.
module instr_fetch_reg_pc_reg
   import instr_fetch_reg_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VAL = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic [XLEN-1:0] load_val_i,
   input  logic            inc_i,
   output logic [XLEN-1:0] q_o
);

   logic [XLEN-1:0] addr_q;

   // A load takes precedence over an increment; the increment wraps modulo 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= RESET_VAL;
      end else if (load_i) begin
         addr_q <= load_val_i;
      end else if (inc_i) begin
         addr_q <= addr_q + ADDR_STEP;
      end
   end

   assign q_o = addr_q;

endmodule

// File: rtl/instr_fetch_reg.sv
// Instruction fetch unit with an instruction register and a REQ/HOLD/DRAIN handshake FSM.
// state | meaning:  REQ = request at fetch_pc | HOLD = IR valid, waiting for decode | DRAIN = finish the stale request
module instr_fetch_reg
   import instr_fetch_reg_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [ILEN-1:0] imem_rdata,
   output logic            ir_valid,
   input  logic            ir_ready,
   output logic [ILEN-1:0] ir,
   output logic [15:0]     imm16,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] fetch_count
);

   fetch_state_e    state_q;
   logic [ILEN-1:0] ir_q;
   logic [XLEN-1:0] pc_q;
   logic            ir_valid_q;
   logic [XLEN-1:0] fetch_count_q;
   logic [XLEN-1:0] drain_addr_q;
   logic [XLEN-1:0] fetch_pc_q;
   logic [XLEN-1:0] fetch_pc_d;
   logic            fetch_pc_load;
   logic            fetch_pc_inc;

   // Redirect wins over ir_ready, so an accept coinciding with a redirect neither advances nor counts.
   always_comb begin
      fetch_pc_load = redirect;
      fetch_pc_d    = word_align(redirect_pc);
      fetch_pc_inc  = (state_q == ST_HOLD) && ir_ready && !redirect;
   end

   instr_fetch_reg_pc_reg #(
      .RESET_VAL (RESET_PC)
   ) u_fetch_pc (
      .clk        (clk),
      .rst        (rst),
      .load_i     (fetch_pc_load),
      .load_val_i (fetch_pc_d),
      .inc_i      (fetch_pc_inc),
      .q_o        (fetch_pc_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_REQ;
         ir_q          <= '0;
         pc_q          <= RESET_PC;
         ir_valid_q    <= 1'b0;
         fetch_count_q <= '0;
         drain_addr_q  <= RESET_PC;
      end else begin
         case (state_q)
            ST_REQ: begin
               if (redirect) begin
                  // A response in the same cycle is dropped; otherwise the old request must still complete.
                  if (!imem_ready) begin
                     drain_addr_q <= fetch_pc_q;
                     state_q      <= ST_DRAIN;
                  end
               end else if (imem_ready) begin
                  ir_q       <= imem_rdata;
                  pc_q       <= fetch_pc_q;
                  ir_valid_q <= 1'b1;
                  state_q    <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (redirect) begin
                  ir_valid_q <= 1'b0;
                  state_q    <= ST_REQ;
               end else if (ir_ready) begin
                  ir_valid_q    <= 1'b0;
                  fetch_count_q <= fetch_count_q + 32'd1;
                  state_q       <= ST_REQ;
               end
            end
            ST_DRAIN: begin
               if (imem_ready) begin
                  state_q <= ST_REQ;
               end
            end
            default: begin
               state_q <= ST_REQ;
            end
         endcase
      end
   end

   assign imem_req    = !rst && (state_q != ST_HOLD);
   assign imem_addr   = (state_q == ST_DRAIN) ? drain_addr_q : fetch_pc_q;
   assign ir_valid    = ir_valid_q;
   assign ir          = ir_q;
   assign imm16       = ir_q[15:0];
   assign pc          = pc_q;
   assign pc_plus4    = pc_q + ADDR_STEP;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Directed testbench for instr_fetch_reg, checking hand-computed expectations with immediate assertions.
module tb_instr_fetch_reg;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        ir_valid;
   logic        ir_ready;
   logic [31:0] ir;
   logic [15:0] imm16;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] fetch_count;

   int vectors;
   int miscompares;

   instr_fetch_reg #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .ir_valid    (ir_valid),
      .ir_ready    (ir_ready),
      .ir          (ir),
      .imm16       (imm16),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .fetch_count (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      imem_ready  = 1'b0;
      imem_rdata  = 32'h0;
      ir_ready    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;

      #3;
      chk("rst_req",   {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, ir_valid}, 32'd0);
      chk("rst_ir",    ir,          32'h0);
      chk("rst_pc",    pc,          32'h0);
      chk("rst_count", fetch_count, 32'h0);
      step();
      step();
      rst = 1'b0;
      #1;
      chk("post_rst_req",  {31'd0, imem_req}, 32'd1);
      chk("post_rst_addr", imem_addr,         32'h0);

      // first fetch: ready at cycle 1, IR valid at cycle 2
      imem_ready = 1'b1;
      imem_rdata = 32'h2008_FFFF;
      step();
      imem_ready = 1'b0;
      chk("f1_valid", {31'd0, ir_valid}, 32'd1);
      chk("f1_ir",    ir,                32'h2008_FFFF);
      chk("f1_imm16", {16'd0, imm16},    32'h0000_FFFF);
      chk("f1_pc",    pc,                32'h0);
      chk("f1_pc4",   pc_plus4,          32'h4);
      chk("f1_req",   {31'd0, imem_req}, 32'd0);

      // decode stalls 5 cycles in HOLD
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_ir",    ir,                32'h2008_FFFF);
         chk("hold_pc",    pc,                32'h0);
         chk("hold_req",   {31'd0, imem_req}, 32'd0);
         chk("hold_valid", {31'd0, ir_valid}, 32'd1);
      end
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0;
      chk("acc1_valid", {31'd0, ir_valid}, 32'd0);
      chk("acc1_count", fetch_count,       32'd1);
      chk("acc1_addr",  imem_addr,         32'h4);
      chk("acc1_req",   {31'd0, imem_req}, 32'd1);

      // memory wait states: request and address held
      for (int i = 0; i < 3; i++) begin
         step();
         chk("wait_req",  {31'd0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr,         32'h4);
      end
      imem_ready = 1'b1;
      imem_rdata = 32'h1234_5678;
      step();
      imem_ready = 1'b0;
      chk("f2_valid", {31'd0, ir_valid}, 32'd1);
      chk("f2_ir",    ir,                32'h1234_5678);
      chk("f2_pc",    pc,                32'h4);
      chk("f2_pc4",   pc_plus4,          32'h8);
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0;
      chk("acc2_count", fetch_count, 32'd2);
      chk("acc2_addr",  imem_addr,   32'h8);

      // redirect while waiting: drain the old address
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      step();
      redirect = 1'b0;
      chk("drain_req",  {31'd0, imem_req}, 32'd1);
      chk("drain_addr", imem_addr,         32'h8);
      step();
      chk("drain_addr2", imem_addr, 32'h8);
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      chk("drain_done_valid", {31'd0, ir_valid}, 32'd0);
      chk("drain_done_addr",  imem_addr,         32'h0000_0100);
      chk("drain_done_req",   {31'd0, imem_req}, 32'd1);
      chk("drain_done_count", fetch_count,       32'd2);
      imem_rdata = 32'hAAAA_0001;
      step();
      imem_ready = 1'b0;
      chk("f3_ir",  ir,       32'hAAAA_0001);
      chk("f3_pc",  pc,       32'h0000_0100);
      chk("f3_pc4", pc_plus4, 32'h0000_0104);

      // redirect coincident with ir_ready in HOLD
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      ir_ready    = 1'b1;
      step();
      redirect = 1'b0;
      ir_ready = 1'b0;
      chk("rdh_valid", {31'd0, ir_valid}, 32'd0);
      chk("rdh_count", fetch_count,       32'd2);
      chk("rdh_addr",  imem_addr,         32'h0000_0200);
      chk("rdh_req",   {31'd0, imem_req}, 32'd1);

      // redirect coincident with imem_ready in REQ: response dropped
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0300;
      imem_ready  = 1'b1;
      imem_rdata  = 32'h0000_0055;
      step();
      redirect = 1'b0;
      chk("rdr_valid", {31'd0, ir_valid}, 32'd0);
      chk("rdr_addr",  imem_addr,         32'h0000_0300);
      chk("rdr_count", fetch_count,       32'd2);
      chk("rdr_ir",    ir,                32'hAAAA_0001);
      imem_rdata = 32'h0000_0066;
      step();
      imem_ready = 1'b0;
      chk("f4_ir", ir, 32'h0000_0066);
      chk("f4_pc", pc, 32'h0000_0300);
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0;
      chk("acc4_count", fetch_count, 32'd3);
      chk("acc4_addr",  imem_addr,   32'h0000_0304);

      // second redirect while already draining overwrites the target
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0400;
      step();
      redirect_pc = 32'h0000_0500;
      step();
      redirect = 1'b0;
      chk("ddr_addr", imem_addr,         32'h0000_0304);
      chk("ddr_req",  {31'd0, imem_req}, 32'd1);
      imem_ready = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      step();
      imem_ready = 1'b0;
      chk("ddr_next_addr",  imem_addr,         32'h0000_0500);
      chk("ddr_next_valid", {31'd0, ir_valid}, 32'd0);

      // wrap at top of address space; low redirect bits ignored
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      imem_ready  = 1'b1;
      step();
      redirect = 1'b0;
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      imem_rdata = 32'h0000_0077;
      step();
      imem_ready = 1'b0;
      chk("wrap_pc",  pc,       32'hFFFF_FFFC);
      chk("wrap_pc4", pc_plus4, 32'h0);
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0;
      chk("wrap_next_addr", imem_addr,   32'h0);
      chk("wrap_count",     fetch_count, 32'd4);

      // reset pulsed mid-wait takes effect immediately
      step();
      rst = 1'b1;
      #1;
      chk("mid_rst_req",   {31'd0, imem_req}, 32'd0);
      chk("mid_rst_valid", {31'd0, ir_valid}, 32'd0);
      chk("mid_rst_ir",    ir,                32'h0);
      chk("mid_rst_pc",    pc,                32'h0);
      chk("mid_rst_count", fetch_count,       32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("rerun_addr", imem_addr,         32'h0);
      chk("rerun_req",  {31'd0, imem_req}, 32'd1);
      imem_ready = 1'b1;
      imem_rdata = 32'h8000_1234;
      step();
      imem_ready = 1'b0;
      chk("rerun_ir",    ir,             32'h8000_1234);
      chk("rerun_imm16", {16'd0, imm16}, 32'h0000_1234);
      chk("rerun_pc4",   pc_plus4,       32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
